// File: rtl/timer_apb_arb.sv
// Two-master round-robin APB arbiter sharing the timer's single APB slave port.
// Optional transfer timeout is enabled by defining TIMER_APB_ARB_TIMEOUT_EN.
module timer_apb_arb #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m0_psel,
    input  logic                m0_penable,
    input  logic                m0_pwrite,
    input  logic [ADDR_W-1:0]   m0_paddr,
    input  logic [DATA_W-1:0]   m0_pwdata,
    input  logic [DATA_W/8-1:0] m0_pstrb,
    output logic [DATA_W-1:0]   m0_prdata,
    output logic                m0_pready,
    output logic                m0_pslverr,
    input  logic                m1_psel,
    input  logic                m1_penable,
    input  logic                m1_pwrite,
    input  logic [ADDR_W-1:0]   m1_paddr,
    input  logic [DATA_W-1:0]   m1_pwdata,
    input  logic [DATA_W/8-1:0] m1_pstrb,
    output logic [DATA_W-1:0]   m1_prdata,
    output logic                m1_pready,
    output logic                m1_pslverr,
    output logic                s_psel,
    output logic                s_penable,
    output logic                s_pwrite,
    output logic [ADDR_W-1:0]   s_paddr,
    output logic [DATA_W-1:0]   s_pwdata,
    output logic [DATA_W/8-1:0] s_pstrb,
    input  logic [DATA_W-1:0]   s_prdata,
    input  logic                s_pready,
    input  logic                s_pslverr,
    output logic [1:0]          gnt,
    output logic                timeout_evt
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;

    state_e                state_q, state_d;
    logic                  last_gnt_q, last_gnt_d;  // 1: m1 was granted most recently
    logic [1:0]            gnt_q, gnt_d;
    logic                  s_psel_q, s_psel_d, s_penable_q, s_penable_d, s_pwrite_q, s_pwrite_d;
    logic [ADDR_W-1:0]     s_paddr_q, s_paddr_d;
    logic [DATA_W-1:0]     s_pwdata_q, s_pwdata_d;
    logic [DATA_W/8-1:0]   s_pstrb_q, s_pstrb_d;
    logic                  done_s, abort_s, ack_s;

    assign done_s = (state_q == ACCESS) && s_pready;
    assign ack_s  = done_s || abort_s;

`ifdef TIMER_APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_evt_q, timeout_evt_d;

    // Wait-cycle counter for the ACCESS phase; abort once it has seen TIMEOUT_CYC stalls
    always_comb begin
        tmo_cnt_d     = tmo_cnt_q;
        abort_s       = (state_q == ACCESS) && !s_pready && (tmo_cnt_q == CNT_MAX);
        timeout_evt_d = abort_s;
        if (state_q == SETUP) begin
            tmo_cnt_d = '0;
        end else if ((state_q == ACCESS) && !s_pready && (tmo_cnt_q != CNT_MAX)) begin
            tmo_cnt_d = tmo_cnt_q + CNT_ONE;
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end

    // Timeout counter and event register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q     <= '0;
            timeout_evt_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    assign timeout_evt = timeout_evt_q;
`else
    assign abort_s     = 1'b0;
    assign timeout_evt = 1'b0;
`endif

    // Arbitration and downstream APB sequencing
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        gnt_d       = gnt_q;
        s_psel_d    = s_psel_q;
        s_penable_d = s_penable_q;
        s_pwrite_d  = s_pwrite_q;
        s_paddr_d   = s_paddr_q;
        s_pwdata_d  = s_pwdata_q;
        s_pstrb_d   = s_pstrb_q;
        case (state_q)
            IDLE: begin
                // m0 wins when alone, or on a tie when m1 was served last
                if (m0_psel && (!m1_psel || last_gnt_q)) begin
                    gnt_d      = 2'b01;
                    last_gnt_d = 1'b0;
                    s_psel_d   = 1'b1;
                    s_pwrite_d = m0_pwrite;
                    s_paddr_d  = m0_paddr;
                    s_pwdata_d = m0_pwdata;
                    s_pstrb_d  = m0_pstrb;
                    state_d    = SETUP;
                end else if (m1_psel) begin
                    gnt_d      = 2'b10;
                    last_gnt_d = 1'b1;
                    s_psel_d   = 1'b1;
                    s_pwrite_d = m1_pwrite;
                    s_paddr_d  = m1_paddr;
                    s_pwdata_d = m1_pwdata;
                    s_pstrb_d  = m1_pstrb;
                    state_d    = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                s_penable_d = 1'b1;
                state_d     = ACCESS;
            end
            ACCESS: begin
                if (ack_s) begin
                    s_psel_d    = 1'b0;
                    s_penable_d = 1'b0;
                    gnt_d       = 2'b00;
                    state_d     = IDLE;
                end else begin
                    state_d = ACCESS;
                end
            end
            default: begin
                s_psel_d    = 1'b0;
                s_penable_d = 1'b0;
                gnt_d       = 2'b00;
                state_d     = IDLE;
            end
        endcase
    end

    // State and downstream bus registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            gnt_q       <= 2'b00;
            s_psel_q    <= 1'b0;
            s_penable_q <= 1'b0;
            s_pwrite_q  <= 1'b0;
            s_paddr_q   <= '0;
            s_pwdata_q  <= '0;
            s_pstrb_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            gnt_q       <= gnt_d;
            s_psel_q    <= s_psel_d;
            s_penable_q <= s_penable_d;
            s_pwrite_q  <= s_pwrite_d;
            s_paddr_q   <= s_paddr_d;
            s_pwdata_q  <= s_pwdata_d;
            s_pstrb_q   <= s_pstrb_d;
        end
    end

    // Response routing: only the owner, and only while it still drives an access phase
    always_comb begin
        m0_pready  = 1'b0;
        m0_pslverr = 1'b0;
        m0_prdata  = '0;
        m1_pready  = 1'b0;
        m1_pslverr = 1'b0;
        m1_prdata  = '0;
        if (ack_s && gnt_q[0] && m0_psel && m0_penable) begin
            m0_pready  = 1'b1;
            m0_pslverr = abort_s || s_pslverr;
            m0_prdata  = abort_s ? '0 : s_prdata;
        end else if (ack_s && gnt_q[1] && m1_psel && m1_penable) begin
            m1_pready  = 1'b1;
            m1_pslverr = abort_s || s_pslverr;
            m1_prdata  = abort_s ? '0 : s_prdata;
        end else begin
            m0_pready = 1'b0;
        end
    end

    assign s_psel    = s_psel_q;
    assign s_penable = s_penable_q;
    assign s_pwrite  = s_pwrite_q;
    assign s_paddr   = s_paddr_q;
    assign s_pwdata  = s_pwdata_q;
    assign s_pstrb   = s_pstrb_q;
    assign gnt       = gnt_q;
endmodule

// File: tb/tb_timer_apb_arb.sv
// Self-checking bench for timer_apb_arb: directed scenarios plus randomized request pairs
// checked against a transaction-level round-robin / latency / memory reference model.
module tb_timer_apb_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_psel, m0_penable, m0_pwrite, m1_psel, m1_penable, m1_pwrite;
    logic [11:0] m0_paddr, m1_paddr, s_paddr;
    logic [31:0] m0_pwdata, m1_pwdata, m0_prdata, m1_prdata, s_pwdata, s_prdata;
    logic [3:0]  m0_pstrb, m1_pstrb, s_pstrb;
    logic        m0_pready, m0_pslverr, m1_pready, m1_pslverr;
    logic        s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
    logic [1:0]  gnt;
    logic        timeout_evt;

    int n_assert = 0;
    int n_fail   = 0;

    // slave memory (environment) and reference memory (model)
    logic [31:0] mem     [16] = '{default: 32'hFFFF_FFFF};
    logic [31:0] ref_mem [16] = '{default: 32'hFFFF_FFFF};
    int          wait_m  [2];
    bit          hang = 1'b0;
    int          acc_cnt = 0;
    int          cur_wait;
    bit          last_m;

    logic        t_wr   [2];
    logic [11:0] t_addr [2];
    logic [31:0] t_wd   [2];
    logic [3:0]  t_st   [2];

    logic [31:0] rd0, rd1, e_rd0, e_rd1;
    logic        er0, er1, e_er0, e_er1;
    int          lat0, lat1, tmo_pulses;
    bit          act0, act1;

    always #5 clk = ~clk;

    timer_apb_arb dut (
        .clk(clk), .rst_n(rst_n),
        .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite), .m0_paddr(m0_paddr),
        .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb), .m0_prdata(m0_prdata), .m0_pready(m0_pready),
        .m0_pslverr(m0_pslverr),
        .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite), .m1_paddr(m1_paddr),
        .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb), .m1_prdata(m1_prdata), .m1_pready(m1_pready),
        .m1_pslverr(m1_pslverr),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite), .s_paddr(s_paddr),
        .s_pwdata(s_pwdata), .s_pstrb(s_pstrb), .s_prdata(s_prdata), .s_pready(s_pready),
        .s_pslverr(s_pslverr), .gnt(gnt), .timeout_evt(timeout_evt)
    );

    // Downstream timer model: per-owner wait states, error above 0x01C
    always_comb begin
        cur_wait  = (gnt == 2'b10) ? wait_m[1] : wait_m[0];
        s_pready  = s_psel && s_penable && !hang && (acc_cnt >= cur_wait);
        s_prdata  = s_pready ? mem[s_paddr[5:2]] : 32'h0;
        s_pslverr = s_pready && s_paddr[5];
    end

    always @(posedge clk) begin
        if (s_psel && s_penable && !s_pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (s_psel && s_penable && s_pready && s_pwrite && !s_paddr[5])
            for (int b = 0; b < 4; b++)
                if (s_pstrb[b]) mem[s_paddr[5:2]][8*b +: 8] <= s_pwdata[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Protocol invariants sampled every cycle
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m0_rdy_gate", m0_pready & ~(m0_psel & m0_penable), 1'b0);
            chk("m1_rdy_gate", m1_pready & ~(m1_psel & m1_penable), 1'b0);
            chk("rdy_excl", m0_pready & m1_pready, 1'b0);
            chk("m0_err_gate", m0_pslverr & ~m0_pready, 1'b0);
            chk("m1_err_gate", m1_pslverr & ~m1_pready, 1'b0);
        end
    end

    task automatic drive(input int id, input logic sel, input logic en, input logic wr,
                         input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        if (id == 0) begin
            m0_psel = sel; m0_penable = en; m0_pwrite = wr; m0_paddr = a; m0_pwdata = d; m0_pstrb = s;
        end else begin
            m1_psel = sel; m1_penable = en; m1_pwrite = wr; m1_paddr = a; m1_pwdata = d; m1_pstrb = s;
        end
    endtask

    // APB master: latency counts cycles from psel rising up to and including the pready cycle
    task automatic xfer(input int id, input logic wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic er, output int lat);
        bit done = 1'b0;
        lat = 0; rd = 32'h0; er = 1'b0;
        @(posedge clk); #1; drive(id, 1'b1, 1'b0, wr, a, d, s);
        while (!done && lat < 200) begin
            @(negedge clk); lat++;
            if ((id == 0) ? m0_pready : m1_pready) begin
                done = 1'b1;
                rd = (id == 0) ? m0_prdata : m1_prdata;
                er = (id == 0) ? m0_pslverr : m1_pslverr;
            end else begin
                @(posedge clk); #1; drive(id, 1'b1, 1'b1, wr, a, d, s);
            end
        end
        @(posedge clk); #1; drive(id, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    endtask

    // Reference: effect of one completed transfer on the register map
    task automatic ref_apply(input int m, output logic [31:0] rd, output logic er);
        int idx;
        idx = int'(t_addr[m][5:2]);
        er  = t_addr[m] >= 12'h020;
        rd  = ref_mem[idx];
        if (t_wr[m] && !er)
            for (int b = 0; b < 4; b++)
                if (t_st[m][b]) ref_mem[idx][8*b +: 8] = t_wd[m][8*b +: 8];
    endtask

    // Requests from the active masters raised in the same cycle; model predicts order and latency
    task automatic run_pair(input bit a0, input bit a1, input string tag);
        int order[$];
        int exp_lat[2];
        logic [31:0] exp_rd[2];
        logic exp_er[2];
        logic [31:0] r0, r1;
        logic x0, x1;
        int l0, l1, t;
        if (a0 && a1) order = last_m ? '{0, 1} : '{1, 0};
        else if (a0) order = '{0};
        else order = '{1};
        t = 0;
        foreach (order[k]) begin
            int m;
            m = order[k];
            t = t + ((k == 0) ? 3 : 3) + wait_m[m];
            exp_lat[m] = t;
            ref_apply(m, exp_rd[m], exp_er[m]);
            last_m = (m == 1);
        end
        fork
            begin if (a0) xfer(0, t_wr[0], t_addr[0], t_wd[0], t_st[0], r0, x0, l0); end
            begin if (a1) xfer(1, t_wr[1], t_addr[1], t_wd[1], t_st[1], r1, x1, l1); end
        join
        if (a0) begin
            chk({tag, "_lat0"}, l0, exp_lat[0]);
            chk({tag, "_err0"}, x0, exp_er[0]);
            if (!t_wr[0]) chk({tag, "_rd0"}, r0, exp_rd[0]);
        end
        if (a1) begin
            chk({tag, "_lat1"}, l1, exp_lat[1]);
            chk({tag, "_err1"}, x1, exp_er[1]);
            if (!t_wr[1]) chk({tag, "_rd1"}, r1, exp_rd[1]);
        end
    endtask

    task automatic set_txn(input int m, input logic wr, input logic [11:0] a, input logic [31:0] d);
        t_wr[m] = wr; t_addr[m] = a; t_wd[m] = d; t_st[m] = 4'hF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; last_m = 1'b1; wait_m = '{0, 0};
        drive(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        #12;
        chk("rst_sctl", {s_psel, s_penable, s_pwrite}, 3'b000);
        chk("rst_saddr", s_paddr, 12'h0);
        chk("rst_swdata", {s_pwdata, s_pstrb}, 36'h0);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_tmo", timeout_evt, 1'b0);
        chk("rst_mresp", {m0_pready, m0_pslverr, m0_prdata, m1_pready, m1_pslverr, m1_prdata}, 68'h0);
        @(negedge clk); rst_n = 1'b1;

        // single write with a phase-by-phase view of the downstream bus
        set_txn(0, 1'b1, 12'h000, 32'h0000_0103);
        fork
            run_pair(1'b1, 1'b0, "wr");
            begin
                @(posedge clk);
                @(negedge clk); chk("wr_idle_gnt", gnt, 2'b00);
                @(negedge clk);
                chk("wr_setup_ctl", {s_psel, s_penable, s_pwrite}, 3'b101);
                chk("wr_setup_bus", {s_paddr, s_pwdata}, {12'h000, 32'h0000_0103});
                chk("wr_setup_gnt", gnt, 2'b01);
                @(negedge clk);
                chk("wr_acc_ctl", {s_psel, s_penable, s_pwrite}, 3'b111);
                chk("wr_acc_bus", {s_paddr, s_pwdata}, {12'h000, 32'h0000_0103});
                chk("wr_acc_gnt", gnt, 2'b01);
                chk("wr_m1_rdy", m1_pready, 1'b0);
                @(negedge clk);
                chk("wr_done_ctl", {s_psel, s_penable, gnt}, 4'h0);
                chk("wr_rdy_1cyc", m0_pready, 1'b0);
            end
        join

        // tie after reset, a lone m0 access, then a second tie
        set_txn(0, 1'b0, 12'h00C, 32'h0); set_txn(1, 1'b0, 12'h010, 32'h0);
        run_pair(1'b1, 1'b1, "tie1");
        set_txn(0, 1'b1, 12'h004, $urandom);
        run_pair(1'b1, 1'b0, "solo");
        set_txn(0, 1'b0, 12'h004, 32'h0); set_txn(1, 1'b0, 12'h000, 32'h0);
        run_pair(1'b1, 1'b1, "tie2");

        // m1 write with 4 wait states; m0 requests two cycles later and must queue
        set_txn(1, 1'b1, 12'h014, $urandom); set_txn(0, 1'b0, 12'h014, 32'h0);
        wait_m = '{0, 4};
        ref_apply(1, e_rd1, e_er1); ref_apply(0, e_rd0, e_er0); last_m = 1'b0;
        fork
            xfer(1, t_wr[1], t_addr[1], t_wd[1], t_st[1], rd1, er1, lat1);
            begin repeat (2) @(posedge clk); xfer(0, t_wr[0], t_addr[0], t_wd[0], t_st[0], rd0, er0, lat0); end
        join
        chk("ws_lat1", lat1, 3 + wait_m[1]);
        chk("ws_lat0", lat0, (3 + wait_m[1]) - 2 + 3 + wait_m[0]);
        chk("ws_rd0", rd0, e_rd0);
        wait_m = '{0, 0};

        // slave error routed to m0 only
        set_txn(0, 1'b1, 12'h020, 32'hDEAD_BEEF);
        run_pair(1'b1, 1'b0, "err");

        // owner abandons its transfer during ACCESS
        @(posedge clk); #1; drive(0, 1'b1, 1'b0, 1'b0, 12'h008, 32'h0, 4'h0);
        @(posedge clk); #1; drive(0, 1'b1, 1'b1, 1'b0, 12'h008, 32'h0, 4'h0);
        @(posedge clk); #1; drive(0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        @(negedge clk);
        chk("drop_rdy", m0_pready, 1'b0);
        chk("drop_s_acc", {s_psel, s_penable, gnt}, 4'b1101);
        @(negedge clk);
        chk("drop_idle", {s_psel, s_penable, gnt}, 4'h0);
        last_m = 1'b0;

`ifdef TIMER_APB_ARB_TIMEOUT_EN
        hang = 1'b1; wait_m = '{16, 0}; tmo_pulses = 0;
        set_txn(0, 1'b0, 12'h01C, 32'h0);
        fork
            xfer(0, t_wr[0], t_addr[0], t_wd[0], t_st[0], rd0, er0, lat0);
            for (int i = 0; i < 25; i++) begin @(negedge clk); if (timeout_evt) tmo_pulses++; end
        join
        hang = 1'b0; wait_m = '{0, 0}; last_m = 1'b0;
        chk("tmo_lat", lat0, 3 + 16);
        chk("tmo_resp", {er0, rd0}, 33'h1_0000_0000);
        chk("tmo_pulses", tmo_pulses, 1);
        run_pair(1'b1, 1'b0, "tmo_next");
`endif

        // reset in the middle of an m0 ACCESS phase
        wait_m = '{5, 0};
        @(posedge clk); #1; drive(0, 1'b1, 1'b0, 1'b0, 12'h00C, 32'h0, 4'h0);
        @(posedge clk); #1; drive(0, 1'b1, 1'b1, 1'b0, 12'h00C, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b0; #1;
        chk("rstmid_sctl", {s_psel, s_penable, s_pwrite}, 3'b000);
        chk("rstmid_saddr", s_paddr, 12'h0);
        chk("rstmid_gnt", gnt, 2'b00);
        chk("rstmid_rdy", {m0_pready, m1_pready}, 2'b00);
        drive(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        @(negedge clk); rst_n = 1'b1; last_m = 1'b1; wait_m = '{0, 0};
        set_txn(0, 1'b0, 12'h00C, 32'h0); set_txn(1, 1'b0, 12'h018, 32'h0);
        run_pair(1'b1, 1'b1, "rsttie");

        // randomized request pairs
        for (int i = 0; i < 40; i++) begin
            act0 = 1'($urandom_range(0, 1));
            act1 = act0 ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int m = 0; m < 2; m++) begin
                t_wr[m]   = 1'($urandom_range(0, 1));
                t_addr[m] = {6'h0, 4'($urandom_range(0, 15)), 2'b00};
                t_wd[m]   = $urandom;
                t_st[m]   = 4'($urandom_range(1, 15));
                wait_m[m] = $urandom_range(0, 3);
            end
            run_pair(act0, act1, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/timer_apb_arb.md
Name: timer_apb_arb

Overview:
- Two-master APB arbiter that shares the timer's single APB slave port, for example between the CPU bridge and the debug/DMA configuration master.
- Accepts independent APB transfers on ports m0/m1 and serialises them onto one downstream APB master port (s_*) that connects to the timer's tim_* bus.
- Uses round-robin fairness, inserts wait states on the losing master, and routes each response only to the master that owns the transfer.

Parameters:
- ADDR_W, 12, address width of all ports (timer map 0x00–0x1C).
- DATA_W, 32, data width; pstrb width is DATA_W/8.
- TIMEOUT_CYC, 16, maximum number of ACCESS cycles waiting for s_pready; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- m0_psel, m0_penable, m0_pwrite  in  1 each  master 0 APB controls.
- m0_paddr  in  ADDR_W  master 0 address.
- m0_pwdata  in  DATA_W  master 0 write data.
- m0_pstrb  in  DATA_W/8  master 0 byte strobes.
- m0_prdata  out  DATA_W  master 0 read data.
- m0_pready  out  1  master 0 ready.
- m0_pslverr  out  1  master 0 error.
- m1_*  same set, same directions and widths, for master 1.
- s_psel, s_penable, s_pwrite  out  1 each  downstream APB controls.
- s_paddr  out  ADDR_W  downstream address.
- s_pwdata  out  DATA_W  downstream write data.
- s_pstrb  out  DATA_W/8  downstream strobes.
- s_prdata  in  DATA_W  downstream read data.
- s_pready  in  1  downstream ready.
- s_pslverr  in  1  downstream error.
- gnt  out  2  one-hot owner of the in-flight transfer; 00 when idle.
- timeout_evt  out  1  one-cycle pulse when a transfer is aborted by timeout.

Behaviour:
- Reset values:
  - All s_* outputs 0.
  - m*_pready, m*_pslverr, m*_prdata 0.
  - gnt 00, timeout_evt 0, state IDLE.
  - last_gnt = 1, so master 0 wins the first tie.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Samples m0_psel and m1_psel.
  - If only one is high, that master is granted.
  - If both are high, grant the master != last_gnt.
  - On grant:
    - Latch pwrite, paddr, pwdata and pstrb from the winner into the s_* registers.
    - Set gnt one-hot and update last_gnt.
    - Go to SETUP.
- SETUP:
  - s_psel=1, s_penable=0, held for exactly 1 cycle.
  - Then go to ACCESS.
- ACCESS:
  - s_psel=1, s_penable=1.
  - Address, data and controls stay constant until completion.
- Completion cycle (ACCESS and s_pready=1):
  - Owner's m_pready = 1, combinational from s_pready.
  - Owner's m_prdata = s_prdata and m_pslverr = s_pslverr, both combinational.
  - Next state is IDLE; s_psel and s_penable drop to 0; gnt returns to 00.
- Non-owner: m_pready stays 0 (stalled), m_prdata = 0, m_pslverr = 0.
- Minimum latency: m_psel rising to m_pready is 3 cycles with a zero-wait timer, i.e. the master sees at least one wait state. Each extra downstream wait state adds one cycle.
- Back-to-back: one IDLE cycle is always inserted between downstream transfers.
- Contested throughput: requests from both masters alternate strictly, m0, m1, m0, …
- Owner drops psel before completion (protocol violation):
  - The downstream transfer still completes.
  - The response is discarded and the owner's m_pready is not asserted.
- A master asserting psel while not granted is simply held: its pready stays 0 until it has been granted and its transfer completes.
- Reset mid-transfer:
  - Everything returns asynchronously to reset values.
  - The in-flight downstream transfer is dropped, with no pready to any master.
- m_pready is never asserted unless that master's psel and penable are both high in the same cycle.

Optional Feature:
- Macro: TIMER_APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle with s_pready=0.
  - When the counter reaches TIMEOUT_CYC, the transfer aborts that cycle:
    - Owner's m_pready=1, m_pslverr=1, m_prdata=0.
    - timeout_evt pulses 1 cycle.
    - Next state IDLE.
  - A late s_pready arriving after the abort is ignored.
- Not defined: no counter logic; timeout_evt tied to 0; ACCESS waits for s_pready indefinitely.

Test Plan:
- Single write: m0 writes addr 0x000, data 0x0000_0103, zero-wait slave -> s_* shows SETUP then ACCESS carrying 0x000/0x103; m0_pready high for 1 cycle, 3 cycles after m0_psel; m1_pready stays 0; gnt=01 during the transfer.
- Tie after reset: m0 reads 0x00C and m1 reads 0x010 in the same cycle -> m0 served first (rdata 0xFFFF_FFFF); m1 served next after 1 IDLE cycle; a second simultaneous pair is served m1 first.
- Wait states: slave holds s_pready low for 4 ACCESS cycles on an m1 write to 0x014 -> m1_pready rises on cycle 7 after m1_psel; m0 request issued meanwhile waits and starts only after m1 completes.
- Error routing: s_pslverr=1 on an m0 write to 0x020 -> m0_pslverr=1 on its completion cycle; m1_pslverr stays 0 throughout.
- Timeout (macro defined, TIMEOUT_CYC=16): s_pready stuck at 0 -> after 16 ACCESS cycles owner sees pready=1, pslverr=1, prdata=0; timeout_evt pulses once; next request proceeds normally.
- Reset mid-ACCESS: assert rst_n=0 during an m0 transfer -> all outputs go to 0 immediately; after release, the next tie is granted to m0.
